// File: rtl/as_tapc_gen.sv
// IEEE 1149.1 TAP controller with an IR, BYPASS and IDCODE data registers,
// plus select/strobe outputs for a configurable number of external DRs.
module as_tapc_gen #(
  parameter int                IR_WIDTH   = 8,
  parameter int                ID_WIDTH   = 32,
  parameter logic [ID_WIDTH-1:0] IDCODE   = 32'h0A57_0001,
  parameter int                NR_EXT_DRS = 3
) (
  input  logic                  tck,
  input  logic                  trst_n,
  input  logic                  tms,
  input  logic                  tdi,
  input  logic [NR_EXT_DRS-1:0] ext_tdo_i,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [3:0]            state_o,
  output logic [IR_WIDTH-1:0]   ir_o,
  output logic [NR_EXT_DRS-1:0] ext_sel_o,
  output logic                  capture_dr_o,
  output logic                  shift_dr_o,
  output logic                  update_dr_o
);

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC,
    SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR    = 4'h2, EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR   = 4'h5,
    SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA, EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

  tap_state_t            r_state;
  logic [IR_WIDTH-1:0]   r_ir;
  logic [IR_WIDTH-1:0]   r_ir_sr;
  logic                  r_bypass;
  logic [ID_WIDTH-1:0]   r_id;

  logic [NR_EXT_DRS-1:0] w_ext_sel;
  logic                  w_sel_id;
  logic                  w_sel_byp;
  logic                  w_dr_tdo;

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      r_state <= TLR;
    end else begin
      case (r_state)
        TLR:      r_state <= tms ? TLR    : RTI;
        RTI:      r_state <= tms ? SEL_DR : RTI;
        SEL_DR:   r_state <= tms ? SEL_IR : CAP_DR;
        CAP_DR:   r_state <= tms ? EX1_DR : SH_DR;
        SH_DR:    r_state <= tms ? EX1_DR : SH_DR;
        EX1_DR:   r_state <= tms ? UPD_DR : PAUSE_DR;
        PAUSE_DR: r_state <= tms ? EX2_DR : PAUSE_DR;
        EX2_DR:   r_state <= tms ? UPD_DR : SH_DR;
        UPD_DR:   r_state <= tms ? SEL_DR : RTI;
        SEL_IR:   r_state <= tms ? TLR    : CAP_IR;
        CAP_IR:   r_state <= tms ? EX1_IR : SH_IR;
        SH_IR:    r_state <= tms ? EX1_IR : SH_IR;
        EX1_IR:   r_state <= tms ? UPD_IR : PAUSE_IR;
        PAUSE_IR: r_state <= tms ? EX2_IR : PAUSE_IR;
        EX2_IR:   r_state <= tms ? UPD_IR : SH_IR;
        UPD_IR:   r_state <= tms ? SEL_DR : RTI;
        default:  r_state <= TLR;
      endcase
    end
  end

  // The active instruction only moves in UpdIR, and is pinned to IDCODE in TLR.
  always_ff @(posedge tck) begin
    if (!trst_n) begin
      r_ir    <= IR_IDCODE;
      r_ir_sr <= '0;
    end else begin
      case (r_state)
        TLR:     r_ir    <= IR_IDCODE;
        CAP_IR:  r_ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
        SH_IR:   r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
        UPD_IR:  r_ir    <= r_ir_sr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck) begin
    if (!trst_n) begin
      r_bypass <= 1'b0;
      r_id     <= IDCODE;
    end else begin
      if (r_state == CAP_DR) begin
        if (w_sel_byp) r_bypass <= 1'b0;
        if (w_sel_id)  r_id     <= IDCODE;
      end else if (r_state == SH_DR) begin
        if (w_sel_byp) r_bypass <= tdi;
        if (w_sel_id)  r_id     <= {tdi, r_id[ID_WIDTH-1:1]};
      end
    end
  end

  // Any code that is neither IDCODE nor an external DR falls through to BYPASS.
  always_comb begin
    w_ext_sel = '0;
    for (int k = 0; k < NR_EXT_DRS; k++) begin
      w_ext_sel[k] = (r_ir == IR_WIDTH'(k + 2));
    end
    w_sel_id  = (r_ir == IR_IDCODE);
    w_sel_byp = !w_sel_id && !(|w_ext_sel);
  end

  always_comb begin
    w_dr_tdo = r_bypass;
    if (w_sel_id)        w_dr_tdo = r_id[0];
    else if (|w_ext_sel) w_dr_tdo = |(w_ext_sel & ext_tdo_i);
  end

  always_comb begin
    tdo = 1'b0;
    if (r_state == SH_IR)      tdo = r_ir_sr[0];
    else if (r_state == SH_DR) tdo = w_dr_tdo;
  end

  assign tdo_en       = (r_state == SH_IR) || (r_state == SH_DR);
  assign state_o      = r_state;
  assign ir_o         = r_ir;
  assign ext_sel_o    = w_ext_sel;
  assign capture_dr_o = (r_state == CAP_DR);
  assign shift_dr_o   = (r_state == SH_DR);
  assign update_dr_o  = (r_state == UPD_DR);

endmodule

// File: tb/tb_as_tapc_gen.sv
// Randomized and directed checks of as_tapc_gen against a table-driven TAP model.
module tb_as_tapc_gen;

  localparam int              IR_W = 8;
  localparam int              ID_W = 32;
  localparam logic [31:0]     IDC  = 32'h0A57_0001;
  localparam int              NR   = 3;

  logic            tck = 1'b0;
  logic            trst_n;
  logic            tms;
  logic            tdi;
  logic [NR-1:0]   ext_tdo_i;
  logic            tdo;
  logic            tdo_en;
  logic [3:0]      state_o;
  logic [IR_W-1:0] ir_o;
  logic [NR-1:0]   ext_sel_o;
  logic            capture_dr_o;
  logic            shift_dr_o;
  logic            update_dr_o;

  int n_checks = 0;
  int n_errors = 0;

  as_tapc_gen #(
    .IR_WIDTH(IR_W), .ID_WIDTH(ID_W), .IDCODE(IDC), .NR_EXT_DRS(NR)
  ) u_dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .ext_tdo_i(ext_tdo_i),
    .tdo(tdo), .tdo_en(tdo_en), .state_o(state_o), .ir_o(ir_o),
    .ext_sel_o(ext_sel_o), .capture_dr_o(capture_dr_o),
    .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o)
  );

  always #5 tck = ~tck;

  // Next-state tables indexed by the 1149.1 state code.
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  logic [3:0]      m_state;
  int              m_ir;
  logic [IR_W-1:0] m_irsr;
  logic            m_byp;
  logic [ID_W-1:0] m_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_ext(input int code);
    return (code >= 2) && (code < NR + 2);
  endfunction

  task automatic model_reset();
    m_state = 4'hF; m_ir = 1; m_irsr = '0; m_byp = 1'b0; m_id = IDC;
  endtask

  task automatic model_edge(input logic t_ms, input logic t_di, input logic rst_n);
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_state)
      4'hF: m_ir = 1;
      4'hE: m_irsr = 1;
      4'hA: m_irsr = (m_irsr >> 1) | (IR_W'(t_di) << (IR_W - 1));
      4'hD: m_ir = int'(m_irsr);
      4'h6: begin
        if (m_ir == 1) m_id = IDC;
        else if (!is_ext(m_ir)) m_byp = 1'b0;
      end
      4'h2: begin
        if (m_ir == 1) m_id = (m_id >> 1) | (ID_W'(t_di) << (ID_W - 1));
        else if (!is_ext(m_ir)) m_byp = t_di;
      end
      default: ;
    endcase
    m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
  endtask

  task automatic check_outputs();
    logic          e_tdo;
    logic [NR-1:0] e_sel;
    e_sel = '0;
    if (is_ext(m_ir)) e_sel[m_ir - 2] = 1'b1;
    e_tdo = 1'b0;
    if (m_state == 4'hA) e_tdo = m_irsr[0];
    else if (m_state == 4'h2) begin
      if (m_ir == 1)          e_tdo = m_id[0];
      else if (is_ext(m_ir))  e_tdo = ext_tdo_i[m_ir - 2];
      else                    e_tdo = m_byp;
    end
    check("state", 32'(state_o), 32'(m_state));
    check("ir", 32'(ir_o), 32'(m_ir));
    check("tdo", 32'(tdo), 32'(e_tdo));
    check("tdo_en", 32'(tdo_en), 32'((m_state == 4'hA) || (m_state == 4'h2)));
    check("ext_sel", 32'(ext_sel_o), 32'(e_sel));
    check("strobes", 32'({capture_dr_o, shift_dr_o, update_dr_o}),
          32'({m_state == 4'h6, m_state == 4'h2, m_state == 4'h5}));
  endtask

  task automatic step(input logic t_ms, input logic t_di, input logic rst_n, output logic o_tdo);
    @(negedge tck);
    tms = t_ms; tdi = t_di; trst_n = rst_n;
    ext_tdo_i = NR'($urandom_range(0, (1 << NR) - 1));
    #1;
    check_outputs();
    o_tdo = tdo;
    @(posedge tck);
    model_edge(t_ms, t_di, rst_n);
  endtask

  task automatic step_tms(input logic t_ms);
    logic d;
    step(t_ms, 1'($urandom_range(0, 1)), 1'b1, d);
  endtask

  // Goes to RTI via TLR, loads v into the IR, returns to RTI; o_cap holds IR tdo bits.
  task automatic load_ir(input logic [IR_W-1:0] v, output logic [IR_W-1:0] o_cap);
    logic d;
    repeat (5) step_tms(1'b1);
    step_tms(1'b0);
    step_tms(1'b1); step_tms(1'b1); step_tms(1'b0); step_tms(1'b0);
    for (int i = 0; i < IR_W; i++) begin
      step(i == IR_W - 1, v[i], 1'b1, d);
      o_cap[i] = d;
    end
    step_tms(1'b1); step_tms(1'b0);
  endtask

  // From RTI: shift n bits of data through the selected DR, back to RTI.
  task automatic shift_dr(input logic [63:0] data, input int n, output logic [63:0] o_cap);
    logic d;
    o_cap = '0;
    step_tms(1'b1); step_tms(1'b0); step_tms(1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, data[i], 1'b1, d);
      o_cap[i] = d;
    end
    step_tms(1'b1); step_tms(1'b0);
  endtask

  initial begin
    logic [63:0]     cap;
    logic [IR_W-1:0] ircap;
    logic [19:0]     seq;
    logic            d;

    trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; ext_tdo_i = '0;
    repeat (2) @(posedge tck);
    model_reset();

    // Reset values, then IDCODE readout straight after reset.
    step(1'b1, 1'b0, 1'b0, d);
    step_tms(1'b0);
    shift_dr(64'h0, 32, cap);
    check("idcode_read", cap[31:0], IDC);

    // IR capture pattern and loading all-ones (BYPASS).
    load_ir(8'hFF, ircap);
    check("ir_capture", 32'(ircap), 32'h01);
    #2 check("ir_ff", 32'(ir_o), 32'hFF);
    shift_dr(64'h0A5, 9, cap);
    check("bypass_a5", cap[31:0], 32'h14A);

    // Five tms=1 edges from ShDR walk back to TLR.
    step_tms(1'b1); step_tms(1'b0); step_tms(1'b0);
    seq = '0;
    for (int i = 0; i < 5; i++) begin
      step_tms(1'b1);
      #2 seq = {seq[15:0], state_o};
    end
    check("tlr_walk", 32'(seq), 32'h1574F);

    // Reset in the middle of a DR shift.
    step_tms(1'b0); step_tms(1'b1); step_tms(1'b0); step_tms(1'b0);
    step_tms(1'b0);
    step(1'b0, 1'b1, 1'b0, d);
    #2;
    check("rst_state", 32'(state_o), 32'hF);
    check("rst_ir", 32'(ir_o), 32'h01);
    check("rst_tdo_en", 32'(tdo_en), 32'h0);

    // External DR 1, then an unused code that must behave as BYPASS.
    load_ir(8'h03, ircap);
    #2 check("ext_sel_1", 32'(ext_sel_o), 32'h2);
    shift_dr(64'($urandom), 12, cap);
    load_ir(8'h40, ircap);
    #2 check("ext_sel_none", 32'(ext_sel_o), 32'h0);
    shift_dr(64'h0A5, 9, cap);
    check("bypass_40", cap[31:0], 32'h14A);

    // IDCODE over-shift: captured value followed by tdi delayed 32 edges.
    load_ir(8'h01, ircap);
    shift_dr(64'hDEAD_BEEF_0000_0000, 48, cap);
    check("idcode_over", 32'(cap[47:0] >> 32), 32'h0);
    check("idcode_cap", cap[31:0], IDC);

    // Random walk with occasional resets and IR loads.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 4))
          0: load_ir(8'h01, ircap);
          1: load_ir(8'h02, ircap);
          2: load_ir(8'h04, ircap);
          3: load_ir(8'hFF, ircap);
          default: load_ir(8'($urandom), ircap);
        endcase
      end else begin
        step($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) != 0, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/as_tapc_gen.md
AS_TAPC_GEN -- requirements
Module: as_tapc_gen

Interface
REQ-001 SHALL have parameter IR_WIDTH, 8, instruction register width (>=2).
REQ-002 SHALL have parameter ID_WIDTH, 32, IDCODE register width.
REQ-003 SHALL have parameter IDCODE, 32'h0A57_0001, value captured into the IDCODE DR (LSB SHALL be 1).
REQ-004 SHALL have parameter NR_EXT_DRS, 3, number of external data registers (>=1, NR_EXT_DRS+2 < 2**IR_WIDTH-1).
REQ-005 Clocking: one clock; reset is synchronous and active-low.
REQ-006 tck  input  1  TAP clock; all state changes on its rising edge.
REQ-007 trst_n  input  1  synchronous active-low reset.
REQ-008 tms  input  1  test mode select, sampled on rising tck.
REQ-009 tdi  input  1  test data in.
REQ-010 ext_tdo_i  input  NR_EXT_DRS  serial outputs of external DRs.
REQ-011 tdo  output  1  test data out.
REQ-012 tdo_en  output  1  tdo valid/drive enable.
REQ-013 state_o  output  4  current TAP state, IEEE 1149.1 encoding.
REQ-014 ir_o  output  IR_WIDTH  current (updated) instruction.
REQ-015 ext_sel_o  output  NR_EXT_DRS  one-hot external DR select.
REQ-016 capture_dr_o / shift_dr_o / update_dr_o  output  1 each  DR strobes for external DRs.

Function
REQ-017 FSM SHALL implement all 16 states with 1149.1 transitions; encoding TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-018 Five consecutive tms=1 edges SHALL reach TLR from any state; TLR with tms=1 stays TLR.
REQ-019 Strobes SHALL be pure decodes of current state (CapDR, ShDR, UpdDR), not gated by selection.
REQ-020 Instruction decode: IR all-ones = BYPASS; IR=1 = IDCODE; IR=k+2 (0<=k<NR_EXT_DRS) selects external DR k; every other code SHALL decode as BYPASS.
REQ-021 ext_sel_o SHALL be one-hot for external codes, all-zero otherwise; derived from ir_o only.
REQ-022 IR shift register: on edge in CapIR loaded with {zeros, 2'b01}; on edge in ShIR shifts right, tdi into MSB; ir_o updated from shift register on edge in UpdIR; no other state changes ir_o.
REQ-023 In TLR, ir_o SHALL be forced to IDCODE (1) on every edge.
REQ-024 BYPASS DR: 1 bit, captured 0 in CapDR, loaded with tdi in ShDR.
REQ-025 IDCODE DR: captures IDCODE in CapDR, shifts right with tdi into MSB in ShDR.
REQ-026 Internal DRs SHALL change only when selected by ir_o; Pause/Exit states hold all shift registers.
REQ-027 tdo SHALL be combinational: ShIR -> IR shift LSB; ShDR -> LSB of selected DR (BYPASS bit, IDCODE LSB, or ext_tdo_i[k]); else 0.
REQ-028 tdo_en SHALL be 1 exactly when state is ShIR or ShDR.
REQ-029 Shift lengths unrestricted: over-shifting SHALL output tdi delayed by register length; no wrap-around of captured data.

Reset
REQ-030 trst_n=0 on an edge SHALL set state TLR, ir_o=1, IR shift=0, BYPASS=0, IDCODE DR=IDCODE, overriding tms, including mid-shift.
REQ-031 After reset: tdo=0, tdo_en=0, ext_sel_o=0, all strobes 0.

Verification
REQ-032 Reset mid-ShDR -> next cycle state_o=F, ir_o=8'h01, tdo_en=0.
REQ-033 From ShDR, tms=1 for 5 edges -> state_o sequence 1,5,7,4,F.
REQ-034 After reset, tms 0,1,0,0 then 32 ShDR edges -> tdo LSB-first equals 32'h0A57_0001.
REQ-035 ShIR after CapIR -> first 8 tdo bits 1,0,0,0,0,0,0,0; shifting in 8'hFF then UpdIR -> ir_o=8'hFF; shift DR 8'hA5 -> tdo = 0 then A5 bits delayed one edge.
REQ-036 Load IR=8'h03 -> ext_sel_o=3'b010, tdo follows ext_tdo_i[1] in ShDR, strobes assert in CapDR/ShDR/UpdDR; load IR=8'h40 -> ext_sel_o=0, BYPASS behaviour.
